// File: rtl/bin2bcd_seq_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_if
// Bundles the request/result signals of the bin2bcd_seq converter.
//
// Signals:
//   start   - conversion request from the master (sampled only while idle)
//   bin     - unsigned binary operand, IN_W bits, captured on the start edge
//   busy    - converter has a conversion in flight
//   done    - one-cycle pulse, bcd (and lz_mask) updated in the same cycle
//   bcd     - packed BCD result, digit 0 (ones) in bits [3:0]
//   lz_mask - leading-zero blanking mask (only with BIN2BCD_LZ_MASK_EN)
//
// Modports:
//   master - requester side (drives start/bin)
//   slave  - converter side (drives busy/done/bcd)
//
// Optional feature macro: BIN2BCD_LZ_MASK_EN adds lz_mask.
// ---------------------------------------------------------------------------
interface bin2bcd_seq_if #(
    parameter int IN_W   = 12,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [IN_W-1:0]       bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
`ifdef BIN2BCD_LZ_MASK_EN
    logic [DIGITS-1:0]     lz_mask;

    modport master (output start, output bin,
                    input  busy,  input  done, input bcd, input lz_mask);
    modport slave  (input  start, input  bin,
                    output busy,  output done, output bcd, output lz_mask);
`else
    modport master (output start, output bin,
                    input  busy,  input  done, input bcd);
    modport slave  (input  start, input  bin,
                    output busy,  output done, output bcd);
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble),
// one input bit per clock. Feeds the BCD-to-seven-segment decoder stage;
// bcd is held between conversions so the display never shows partial values.
//
// Parameters:
//   IN_W   - binary input width (default 12)
//   DIGITS - number of BCD digits (default 4); must satisfy
//            10**DIGITS > 2**IN_W - 1 so no digit can overflow
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous reset, active high
//   bus       - bin2bcd_seq_if.slave (start, bin, busy, done, bcd[, lz_mask])
//   dbg_state - current FSM state (IDLE=0, SHIFT=1, DONE=2)
//
// Optional feature macro: BIN2BCD_LZ_MASK_EN
//   Adds bus.lz_mask: bit k (k>=1) set when digit k and every more
//   significant digit are zero; bit 0 is always 0. Registered with bcd.
//
// Handshake: a request is taken when start=1 at a rising edge while the
// FSM is IDLE (busy=0); bin is captured on that edge. start is ignored
// (not queued) while busy=1 or in the DONE state. Completion is a single
// cycle done=1, with bcd already valid in that cycle. A start asserted in
// the done cycle is accepted, so conversions can run every IN_W+2 clocks.
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int IN_W   = 12,
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bin2bcd_seq_if.slave         bus,
    output logic [1:0]           dbg_state
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + IN_W;
    localparam int CNT_W  = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_n;

    logic [WORK_W-1:0]   work;       // {bcd digits, remaining binary bits}
    logic [WORK_W-1:0]   work_adj;   // work after the per-digit +3 step
    logic [CNT_W-1:0]    cnt;
    logic [BCD_W-1:0]    bcd_q;
    logic                done_q;

    logic                do_load;
    logic                do_shift;
    logic                do_finish;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        do_load   = 1'b0;
        do_shift  = 1'b0;
        do_finish = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    do_load = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                do_shift = 1'b1;
                // cnt still holds the pre-increment value here, so IN_W-1
                // marks the edge that performs the final iteration.
                if (cnt == CNT_W'(IN_W - 1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                do_finish = 1'b1;
                state_n   = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Add-3 correction: any BCD digit >= 5 would become >= 10 after the
    // shift, so pre-add 3 to make the carry land in the next digit.
    // Addition stays inside the nibble.
    // ------------------------------------------------------------------
    always_comb begin
        work_adj = work;
        for (int k = 0; k < DIGITS; k++) begin
            if (work[IN_W + 4*k +: 4] >= 4'd5) begin
                work_adj[IN_W + 4*k +: 4] = work[IN_W + 4*k +: 4] + 4'd3;
            end
        end
    end

`ifdef BIN2BCD_LZ_MASK_EN
    logic [DIGITS-1:0] lz_next;
    logic [DIGITS-1:0] lz_q;
    logic              zero_run;

    // Walk from the most significant digit down; a digit is blanked only
    // while every digit above it (and itself) is zero. Digit 0 never
    // blanks so a value of zero still shows one "0".
    always_comb begin
        lz_next  = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run & (work[IN_W + 4*k +: 4] == 4'd0);
            lz_next[k] = zero_run;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Datapath: working register, iteration counter, result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            work   <= '0;
            cnt    <= '0;
            bcd_q  <= '0;
            done_q <= 1'b0;
`ifdef BIN2BCD_LZ_MASK_EN
            lz_q   <= '0;
`endif
        end else begin
            done_q <= do_finish;
            if (do_load) begin
                work <= {{BCD_W{1'b0}}, bus.bin};
                cnt  <= '0;
            end else if (do_shift) begin
                work <= work_adj << 1;
                cnt  <= cnt + CNT_W'(1);
            end
            if (do_finish) begin
                bcd_q <= work[WORK_W-1 -: BCD_W];
`ifdef BIN2BCD_LZ_MASK_EN
                lz_q  <= lz_next;
`endif
            end
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = done_q;
    assign bus.bcd   = bcd_q;
`ifdef BIN2BCD_LZ_MASK_EN
    assign bus.lz_mask = lz_q;
`endif
    assign dbg_state = state;

endmodule
